// File: rtl/blk_mem_arbiter.sv
// Block-wide memory port arbiter for I-cache refill, D-cache refill and D-cache writeback.
// One 256-bit transaction at a time; fixed priority with an I-side starvation guard.
module blk_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int BLK_W        = 256,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BLK_W-1:0]  i_data,
  output logic              i_done,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_blk_read,
  output logic              mem_blk_write,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_rd_valid,
  input  logic              mem_wr_valid,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(31);

  typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, RESP} state_t;

  state_t            state;
  logic              owner_i;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]  wdata_q;
  logic              gnt_i;
  logic              gnt_dw;
  logic              gnt_dr;

  // Starvation guard overrides the fixed D-over-I priority
  always_comb begin
    gnt_i  = 1'b0;
    gnt_dw = 1'b0;
    gnt_dr = 1'b0;
    if (state == IDLE) begin
      if (i_req && (starve_cnt == LIMIT)) gnt_i  = 1'b1;
      else if (d_wr_req)                  gnt_dw = 1'b1;
      else if (d_rd_req)                  gnt_dr = 1'b1;
      else if (i_req)                     gnt_i  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      owner_i    <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      i_data     <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_i) begin
            state      <= IRD;
            owner_i    <= 1'b1;
            addr_q     <= i_addr & ALIGN;
            starve_cnt <= '0;
          end else if (gnt_dw || gnt_dr) begin
            state   <= gnt_dw ? DWR : DRD;
            owner_i <= 1'b0;
            addr_q  <= d_addr & ALIGN;
            if (i_req && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        IRD, DRD: begin
          if (mem_rd_valid) begin
            if (state == IRD) i_data  <= mem_rdata;
            else              d_rdata <= mem_rdata;
            state <= RESP;
          end
        end
        DWR:     if (mem_wr_valid) state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback data is only observable in DWR, so it needs no reset
  always_ff @(posedge CLK) begin
    if (gnt_dw) wdata_q <= d_wdata;
  end

  assign mem_addr      = addr_q;
  assign mem_blk_read  = (state == IRD) || (state == DRD);
  assign mem_blk_write = (state == DWR);
  assign mem_wdata     = (state == DWR) ? wdata_q : '0;
  assign i_done        = (state == RESP) && owner_i;
  assign d_done        = (state == RESP) && !owner_i;
  assign busy          = (state != IDLE);

endmodule
